alu_sequencer: RTL

Multi-cycle ALU operation sequencer. It accepts one operation at a time over a valid/ready request channel. Add, subtract and shift complete in a single cycle. Unsigned multiply (shift-add) and unsigned divide (restoring) run iteratively, one bit per cycle. Sits between the instruction-issue logic and the register write-back, and holds each result until write-back consumes it.

---
 rtl/alu_sequencer_if.sv | 30 +++
 rtl/alu_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/result channel of the ALU sequencer.
//   Request : op_valid/op_ready handshake carrying opcode, operand1,
//             operand2 and status_in (carry-in for ADD).
//   Result  : res_valid/res_ready handshake carrying result, result_hi
//             and status_out {E,N,Z,C,V}; busy reports a non-idle sequencer.
//   master  : issue/write-back side.  slave : the sequencer.
interface alu_sequencer_if #(parameter int WIDTH = 8);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             status_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [4:0]       status_out;
  logic             busy;

  modport master (
    output op_valid, opcode, operand1, operand2, status_in, res_ready,
    input  op_ready, res_valid, result, result_hi, status_out, busy
  );

  modport slave (
    input  op_valid, opcode, operand1, operand2, status_in, res_ready,
    output op_ready, res_valid, result, result_hi, status_out, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU operation sequencer.
//   ADD/SUB/SHL/SHR and error cases finish one edge after accept;
//   MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
//   The result is held in DONE until res_ready is seen.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (aborts any operation)
//   bus    : alu_sequencer_if.slave (request and result channels, busy)
// Optional build macro ALU_MUL_EARLY_EXIT_EN: MUL leaves EXEC once the
//   remaining multiplier bits are all zero; operand2==0 finishes in one edge.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_MUL  = 3'b100,
    OP_DIV  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } op_e;

  state_e state, state_nx;

  // Iterative datapath
  logic                 is_mul;
  logic [SW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;      // running product
  logic [2*WIDTH-1:0]   mcand;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]     mplier;   // unconsumed multiplier bits
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;      // holds dividend bits, fills with quotient
  logic [WIDTH-1:0]     dvsr;

  // Held result
  logic [WIDTH-1:0]     res_q;
  logic [WIDTH-1:0]     hi_q;
  logic [4:0]           st_q;

  // Single-cycle decode of the incoming request
  logic [WIDTH-1:0]     a, b;
  logic [SW-1:0]        amt;
  logic [WIDTH:0]       sum, diff, shl, shr;
  logic [WIDTH-1:0]     sc_res, sc_hi;
  logic                 sc_c, sc_v, sc_e, go_exec;

  always_comb begin
    a       = bus.operand1;
    b       = bus.operand2;
    amt     = b[SW-1:0];
    sum     = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(bus.status_in);
    diff    = {1'b0, a} - {1'b0, b};
    shl     = {1'b0, a} << amt;
    shr     = {a, 1'b0} >> amt;
    sc_res  = '0;
    sc_hi   = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_e    = 1'b0;
    go_exec = 1'b0;
    case (op_e'(bus.opcode))
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // One extra bit on the far side catches the last bit shifted out;
      // it stays 0 for a zero shift amount.
      OP_SHL: begin
        sc_res = shl[WIDTH-1:0];
        sc_c   = shl[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr[WIDTH:1];
        sc_c   = shr[0];
      end
      OP_MUL: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
        go_exec = (b != '0);
`else
        go_exec = 1'b1;
`endif
      end
      OP_DIV: begin
        if (b == '0) begin
          sc_res = '1;
          sc_hi  = a;
          sc_e   = 1'b1;
        end else begin
          go_exec = 1'b1;
        end
      end
      default: sc_e = 1'b1;
    endcase
  end

  // One multiply / divide iteration
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff, rem_nx, quo_nx;
  logic               div_ge, last, fin;

  always_comb begin
    acc_nx   = acc + (mplier[0] ? mcand : '0);
    div_sh   = {rem, quo[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, dvsr});
    // rem < dvsr, so a successful trial difference always fits WIDTH bits
    div_diff = div_sh[WIDTH-1:0] - dvsr;
    rem_nx   = div_ge ? div_diff : div_sh[WIDTH-1:0];
    quo_nx   = {quo[WIDTH-2:0], div_ge};
    last     = (count == SW'(WIDTH-1));
`ifdef ALU_MUL_EARLY_EXIT_EN
    fin      = is_mul ? (last || (mplier[WIDTH-1:1] == '0)) : last;
`else
    fin      = last;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.op_valid) state_nx = go_exec ? S_EXEC : S_DONE;
      S_EXEC: if (fin)          state_nx = S_DONE;
      S_DONE: if (bus.res_ready) state_nx = S_IDLE;
      default:                  state_nx = S_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_mul <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      res_q  <= '0;
      hi_q   <= '0;
      st_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.op_valid) begin
            is_mul <= (op_e'(bus.opcode) == OP_MUL);
            count  <= '0;
            acc    <= '0;
            mcand  <= (2*WIDTH)'(a);
            mplier <= b;
            rem    <= '0;
            quo    <= a;
            dvsr   <= b;
            if (!go_exec) begin
              res_q <= sc_res;
              hi_q  <= sc_hi;
              st_q  <= {sc_e, sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
            end
          end
        end
        S_EXEC: begin
          count <= count + SW'(1);
          if (is_mul) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (fin) begin
              res_q <= acc_nx[WIDTH-1:0];
              hi_q  <= acc_nx[2*WIDTH-1:WIDTH];
              st_q  <= {1'b0, acc_nx[WIDTH-1], (acc_nx == '0),
                        (acc_nx[2*WIDTH-1:WIDTH] != '0), 1'b0};
            end
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            if (fin) begin
              res_q <= quo_nx;
              hi_q  <= rem_nx;
              st_q  <= {1'b0, quo_nx[WIDTH-1], (quo_nx == '0), 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op_ready   = (state == S_IDLE);
  assign bus.res_valid  = (state == S_DONE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.result     = res_q;
  assign bus.result_hi  = hi_q;
  assign bus.status_out = st_q;

endmodule
